// File: rtl/arb_req_frontend.sv
// Request frontend for a 4-way arbiter: four per-source FIFOs drive req0..3.
// Each valid grant pops one FIFO head onto a registered, source-tagged output bus.

module arb_req_frontend_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] head,
    output logic [AW:0]   count
);
    logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
    logic [AW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]              cnt_q, cnt_d;

    // push/pop arrive already qualified by the parent (not full / not empty)
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) rptr_d = rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head  = mem_q[rptr_q];
    assign count = cnt_q;
endmodule

module arb_req_frontend #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      in_valid,
    input  logic [4*DW-1:0] in_data,
    output logic [3:0]      in_ready,
    output logic            req0,
    output logic            req1,
    output logic            req2,
    output logic            req3,
    input  logic            gnt0,
    input  logic            gnt1,
    input  logic            gnt2,
    input  logic            gnt3,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_src,
    output logic            ovf_err,
    output logic            gnt_err
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [3:0]               gnt, req, push, pop;
    logic [3:0][DW-1:0]       head;
    logic [3:0][AW:0]         cnt;
    logic                     gnt_multi, gnt_single;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [1:0]    out_src_q, out_src_d;
    logic          ovf_err_q, ovf_err_d;
    logic          gnt_err_q, gnt_err_d;

    assign gnt = {gnt3, gnt2, gnt1, gnt0};

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_src
            assign in_ready[i] = (cnt[i] != FULL);
            assign req[i]      = (cnt[i] != '0);
            arb_req_frontend_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (push[i]),
                .pop   (pop[i]),
                .wdata (in_data[i*DW +: DW]),
                .head  (head[i]),
                .count (cnt[i])
            );
        end
    endgenerate

    // x & (x-1) is non-zero exactly when more than one grant bit is set
    assign gnt_multi  = |(gnt & (gnt - 4'd1));
    assign gnt_single = (gnt != 4'd0) && !gnt_multi;
    assign pop        = gnt_single ? (gnt & req) : 4'd0;
    assign push       = in_valid & in_ready;

    always_comb begin
        out_valid_d = |pop;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        for (int k = 0; k < 4; k++) begin
            if (pop[k]) begin
                out_data_d = head[k];
                out_src_d  = 2'(k);
            end
        end
        ovf_err_d = ovf_err_q | (|(in_valid & ~in_ready));
        gnt_err_d = gnt_err_q | gnt_multi | (|(gnt & ~req));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ovf_err_q   <= 1'b0;
            gnt_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ovf_err_q   <= ovf_err_d;
            gnt_err_q   <= gnt_err_d;
        end
    end

    assign {req3, req2, req1, req0} = req;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign ovf_err   = ovf_err_q;
    assign gnt_err   = gnt_err_q;
endmodule

// File: doc/arb_req_frontend.md
Name: arb_req_frontend

Overview:
- Upstream stage of the 4-way round-robin arbiter.
- Buffers transactions from four independent sources in per-source FIFOs and drives the arbiter's req0..req3 lines.
- On each grant (gnt0..gnt3), pops the granted FIFO head and presents it, tagged with its source index, on one registered shared output bus.

Parameters:
- DW, 8, data width of one transaction.
- DEPTH, 4, entries per source FIFO; power of two, >= 2.
- AW, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-low reset; all state clears while low.
- in_valid  input  4  per-source push request; bit i belongs to source i.
- in_data  input  4*DW  source i data at bits [i*DW +: DW].
- in_ready  output  4  per-source FIFO not full.
- req0, req1, req2, req3  output  1 each  to arbiter; reqi = FIFO i non-empty.
- gnt0, gnt1, gnt2, gnt3  input  1 each  from arbiter; expected one-hot or zero.
- out_valid  output  1  out_data/out_src valid this cycle (single-cycle pulse per pop).
- out_data  output  DW  popped transaction.
- out_src  output  2  index of the source that was popped.
- ovf_err  output  1  sticky; push attempted while in_ready=0.
- gnt_err  output  1  sticky; grant to an empty FIFO, or more than one gnt high.

Behaviour:
- Reset (rst=0, async):
  - All FIFOs empty; read/write pointers and counts = 0.
  - in_ready=4'b1111, req0..3=0, out_valid=0, out_data=0, out_src=0, ovf_err=0, gnt_err=0.
  - Asserting reset mid-operation discards all buffered entries; nothing is emitted afterwards.
- FIFO i (AW-bit pointers, count 0..DEPTH with AW+1 bits):
  - Push when in_valid[i] && in_ready[i]: write mem[wptr], wptr+1 wrapping modulo DEPTH.
  - in_ready[i] = (count_i != DEPTH), combinational from registered count.
  - No bypass: a full FIFO rejects a push even if it pops in the same cycle.
  - in_valid[i]=1 while full: entry dropped, ovf_err set (sticky until reset).
  - Same-cycle push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
  - Push into an empty FIFO: reqi rises the next cycle (no same-cycle pass-through).
- reqi = (count_i != 0), combinational from registered count, so it drops the cycle after the last entry pops.
- Grant handling, per rising edge:
  - Exactly one gnti high and count_i != 0: pop FIFO i at this edge.
  - Registered output, 1 cycle after the grant edge: out_valid=1, out_data=old head, out_src=i.
  - No valid pop: out_valid=0; out_data/out_src hold their previous values.
  - gnti high with count_i == 0: no pop, out_valid=0, gnt_err set.
  - More than one gnt high: no pop on any FIFO, out_valid=0, gnt_err set.
  - All gnt low: idle.
- Throughput: one pop per cycle maximum, back-to-back grants allowed. A source holding gnt for N consecutive cycles pops N entries while non-empty.
- No backpressure on the output; the consumer must accept every out_valid cycle.
- Order: FIFO order within a source. Cross-source order is set entirely by the grant sequence.

Test Plan:
- Reset: hold rst=0 with random in_valid/gnt, then release. Required: req0..3=0, in_ready=4'hF, out_valid=0, both error flags 0.
- Single push: push 0xA5 on source 1, then gnt1 for one cycle. Required: req1 high from the cycle after the push; out_valid=1, out_data=0xA5, out_src=1 one cycle after the grant edge; req1 low the following cycle.
- Fill and overflow (DEPTH=4): push 0x10..0x13 on source 2, then a fifth push of 0x14. Required: in_ready[2]=0 after four pushes; ovf_err=1; grants pop 0x10, 0x11, 0x12, 0x13 in order; 0x14 never appears; pointers wrap cleanly on a refill.
- Round-robin flow: load all four sources with 2 entries each (source i data = 0xi0, 0xi1), then drive gnt0, gnt1, gnt2, gnt3, gnt0, gnt1, gnt2, gnt3 one per cycle. Required: eight consecutive out_valid pulses with out_src 0,1,2,3,0,1,2,3 and matching data; all req low at the end.
- Simultaneous push and pop: source 3 holds 1 entry; push 0x77 and gnt3 in the same cycle. Required: old head output, count stays 1, req3 stays high; the next gnt3 outputs 0x77.
- Error and reset mid-stream: gnt0 on an empty FIFO, then gnt1+gnt2 together with both FIFOs non-empty. Required: gnt_err=1, no out_valid, counts unchanged. Then assert rst with FIFOs partly full. Required: all outputs return to reset values immediately (async) and no stale data is emitted after release.
